icache_refill: RTL and testbench

- Sits on the IFU side of the memory crossbar, directly upstream of the crossbar's IFU read port.
- Accepts a cache-miss request from the instruction cache.
- Issues one AXI INCR burst read for the whole line and streams the returned beats into the cache data array.
- Signals completion with an error summary.
- Read-only master: no AW/W/B channels.

---
 rtl/icache_refill.sv | 111 +++++++++++
 tb/tb_icache_refill.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill.sv
// Instruction-cache line refill engine: one AXI INCR burst read per miss,
// beats streamed into the cache data array, completion pulse with error summary.
module icache_refill #(
   parameter int LINE_WORDS  = 4,
   parameter int OFFSET_BITS = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          miss_valid,
   input  logic [31:0]                   miss_addr,
   output logic                          miss_ready,
   output logic                          fill_wen,
   output logic [$clog2(LINE_WORDS)-1:0] fill_idx,
   output logic [31:0]                   fill_data,
   output logic                          fill_done,
   output logic                          fill_err,
   output logic [31:0]                   ifu_araddr,
   output logic                          ifu_arvalid,
   input  logic                          ifu_arready,
   output logic [1:0]                    ifu_arburst,
   output logic [3:0]                    ifu_arlen,
   input  logic [31:0]                   ifu_rdata,
   input  logic [1:0]                    ifu_rresp,
   input  logic                          ifu_rlast,
   input  logic                          ifu_rvalid,
   output logic                          ifu_rready
);
   // state | meaning
   // IDLE  | waiting for a miss, miss_ready high
   // AR    | burst address presented, waiting for arready
   // R     | accepting beats, writing words into the line
   // DONE  | one-cycle completion pulse with error summary

   localparam int IDX_W = $clog2(LINE_WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_WORDS - 1);

   typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;

   state_t           state, state_next;
   logic [IDX_W-1:0] cnt;
   logic             err;
   logic [31:0]      araddr;
   logic             beat;
   logic             last_beat;

   assign ifu_arburst = 2'b01;
   assign ifu_arlen   = 4'(LINE_WORDS - 1);
   assign ifu_araddr  = araddr;
   assign fill_idx    = cnt;
   assign fill_data   = ifu_rdata;

   // rlast or the final count, whichever comes first, ends the line
   assign beat      = (state == R) && ifu_rvalid;
   assign last_beat = ifu_rlast || (cnt == LAST_IDX);

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         err    <= 1'b0;
         araddr <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && miss_valid) begin
            araddr <= {miss_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            cnt    <= '0;
            err    <= 1'b0;
         end
         if (beat) begin
            cnt <= cnt + 1'b1;
            // disagreement between rlast and the count marks a malformed burst
            if ((ifu_rresp != 2'b00) ||
                (last_beat && (ifu_rlast != (cnt == LAST_IDX))))
               err <= 1'b1;
         end
      end
   end

   always_comb begin
      state_next  = state;
      miss_ready  = 1'b0;
      ifu_arvalid = 1'b0;
      ifu_rready  = 1'b0;
      fill_wen    = 1'b0;
      fill_done   = 1'b0;
      fill_err    = 1'b0;
      case (state)
         IDLE: begin
            miss_ready = 1'b1;
            if (miss_valid) state_next = AR;
         end
         AR: begin
            ifu_arvalid = 1'b1;
            if (ifu_arready) state_next = R;
         end
         R: begin
            ifu_rready = 1'b1;
            if (ifu_rvalid) begin
               fill_wen = 1'b1;
               if (last_beat) state_next = DONE;
            end
         end
         DONE: begin
            fill_done  = 1'b1;
            fill_err   = err;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill (LINE_WORDS=4): normal line, bad rresp,
// early and missing rlast, rvalid gaps, held miss_valid and mid-burst reset.
module tb_icache_refill;
   logic        clock = 1'b0;
   logic        reset;
   logic        miss_valid;
   logic [31:0] miss_addr;
   logic        miss_ready;
   logic        fill_wen;
   logic [1:0]  fill_idx;
   logic [31:0] fill_data;
   logic        fill_done;
   logic        fill_err;
   logic [31:0] ifu_araddr;
   logic        ifu_arvalid;
   logic        ifu_arready;
   logic [1:0]  ifu_arburst;
   logic [3:0]  ifu_arlen;
   logic [31:0] ifu_rdata;
   logic [1:0]  ifu_rresp;
   logic        ifu_rlast;
   logic        ifu_rvalid;
   logic        ifu_rready;

   int errors = 0;
   int checks = 0;

   icache_refill #(.LINE_WORDS(4), .OFFSET_BITS(4)) dut (
      .clock(clock), .reset(reset),
      .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_ready(miss_ready),
      .fill_wen(fill_wen), .fill_idx(fill_idx), .fill_data(fill_data),
      .fill_done(fill_done), .fill_err(fill_err),
      .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
      .ifu_arburst(ifu_arburst), .ifu_arlen(ifu_arlen),
      .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rlast(ifu_rlast),
      .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Accept a miss in IDLE, hold AR for 'delay' cycles, then handshake into R.
   task automatic start(input logic [31:0] addr, input logic [31:0] exp_addr,
                        input int delay, input logic hold);
      miss_valid = 1'b1;
      miss_addr  = addr;
      #1;
      chk("idle_miss_ready", miss_ready, 1);
      chk("idle_arvalid", ifu_arvalid, 0);
      tick();
      if (!hold) miss_valid = 1'b0;
      #1;
      chk("ar_arvalid", ifu_arvalid, 1);
      chk("ar_araddr", ifu_araddr, exp_addr);
      chk("ar_arlen", ifu_arlen, 3);
      chk("ar_arburst", ifu_arburst, 1);
      chk("ar_miss_ready", miss_ready, 0);
      chk("ar_rready", ifu_rready, 0);
      for (int i = 0; i < delay; i++) begin
         tick();
         #1;
         chk("ar_hold_arvalid", ifu_arvalid, 1);
         chk("ar_hold_araddr", ifu_araddr, exp_addr);
      end
      ifu_arready = 1'b1;
      tick();
      ifu_arready = 1'b0;
   endtask

   task automatic beat(input logic [31:0] data, input logic [1:0] resp,
                       input logic last, input logic [1:0] exp_idx);
      ifu_rvalid = 1'b1;
      ifu_rdata  = data;
      ifu_rresp  = resp;
      ifu_rlast  = last;
      #1;
      chk("r_rready", ifu_rready, 1);
      chk("r_fill_wen", fill_wen, 1);
      chk("r_fill_idx", fill_idx, exp_idx);
      chk("r_fill_data", fill_data, data);
      chk("r_miss_ready", miss_ready, 0);
      chk("r_fill_done", fill_done, 0);
      tick();
      ifu_rvalid = 1'b0;
      ifu_rlast  = 1'b0;
      ifu_rresp  = 2'b00;
   endtask

   task automatic gap();
      ifu_rvalid = 1'b0;
      #1;
      chk("gap_fill_wen", fill_wen, 0);
      chk("gap_rready", ifu_rready, 1);
      tick();
   endtask

   // In DONE: optional stray rvalid must not be consumed.
   task automatic finish(input logic exp_err, input logic stray);
      ifu_rvalid = stray;
      ifu_rdata  = 32'hDEAD_BEEF;
      #1;
      chk("done_fill_done", fill_done, 1);
      chk("done_fill_err", fill_err, exp_err);
      chk("done_fill_wen", fill_wen, 0);
      chk("done_rready", ifu_rready, 0);
      chk("done_miss_ready", miss_ready, 0);
      tick();
      ifu_rvalid = 1'b0;
      #1;
      chk("post_fill_done", fill_done, 0);
   endtask

   initial begin
      reset = 1'b1;
      miss_valid = 1'b0; miss_addr = '0; ifu_arready = 1'b0;
      ifu_rdata = '0; ifu_rresp = 2'b00; ifu_rlast = 1'b0; ifu_rvalid = 1'b0;
      tick(); tick();
      #1;
      chk("rst_miss_ready", miss_ready, 1);
      chk("rst_arvalid", ifu_arvalid, 0);
      chk("rst_rready", ifu_rready, 0);
      chk("rst_fill_wen", fill_wen, 0);
      chk("rst_fill_done", fill_done, 0);
      chk("rst_fill_err", fill_err, 0);
      chk("rst_araddr", ifu_araddr, 0);
      reset = 1'b0;
      tick();

      // IDLE with stray rvalid: not consumed
      ifu_rvalid = 1'b1;
      #1;
      chk("idle_rready", ifu_rready, 0);
      chk("idle_fill_wen", fill_wen, 0);
      ifu_rvalid = 1'b0;

      // Normal line, arready after 2 cycles
      start(32'h3000_0014, 32'h3000_0010, 2, 1'b0);
      beat(32'h11, 2'b00, 1'b0, 0);
      beat(32'h22, 2'b00, 1'b0, 1);
      beat(32'h33, 2'b00, 1'b0, 2);
      beat(32'h44, 2'b00, 1'b1, 3);
      finish(1'b0, 1'b0);

      // SLVERR on beat 2: all words still written, error reported
      start(32'h3000_0014, 32'h3000_0010, 0, 1'b0);
      beat(32'h11, 2'b00, 1'b0, 0);
      beat(32'h22, 2'b10, 1'b0, 1);
      beat(32'h33, 2'b00, 1'b0, 2);
      beat(32'h44, 2'b00, 1'b1, 3);
      finish(1'b1, 1'b0);

      // Early rlast on beat 3: no fourth write even with rvalid in DONE
      start(32'h0000_1008, 32'h0000_1000, 1, 1'b0);
      beat(32'hA1, 2'b00, 1'b0, 0);
      beat(32'hA2, 2'b00, 1'b0, 1);
      beat(32'hA3, 2'b00, 1'b1, 2);
      finish(1'b1, 1'b1);

      // Missing rlast on the final beat
      start(32'h0000_2000, 32'h0000_2000, 0, 1'b0);
      beat(32'hB1, 2'b00, 1'b0, 0);
      beat(32'hB2, 2'b00, 1'b0, 1);
      beat(32'hB3, 2'b00, 1'b0, 2);
      beat(32'hB4, 2'b00, 1'b0, 3);
      finish(1'b1, 1'b0);

      // rvalid gaps of 0, 2, 1 idle cycles
      start(32'h4000_003C, 32'h4000_0030, 0, 1'b0);
      beat(32'hC1, 2'b00, 1'b0, 0);
      beat(32'hC2, 2'b00, 1'b0, 1);
      gap(); gap();
      beat(32'hC3, 2'b00, 1'b0, 2);
      gap();
      beat(32'hC4, 2'b00, 1'b1, 3);
      finish(1'b0, 1'b0);

      // miss_valid held across a refill: next AR only after IDLE re-accepts
      start(32'h5000_0004, 32'h5000_0000, 0, 1'b1);
      beat(32'hD1, 2'b00, 1'b0, 0);
      beat(32'hD2, 2'b00, 1'b0, 1);
      beat(32'hD3, 2'b00, 1'b0, 2);
      beat(32'hD4, 2'b00, 1'b1, 3);
      #1;
      chk("held_done_arvalid", ifu_arvalid, 0);
      chk("held_done_fill_done", fill_done, 1);
      tick();
      #1;
      chk("held_idle_miss_ready", miss_ready, 1);
      chk("held_idle_arvalid", ifu_arvalid, 0);
      tick();
      miss_valid = 1'b0;
      #1;
      chk("held_second_arvalid", ifu_arvalid, 1);
      chk("held_second_araddr", ifu_araddr, 32'h5000_0000);
      ifu_arready = 1'b1;
      tick();
      ifu_arready = 1'b0;

      // Reset after beat 2 of the second refill
      beat(32'hE1, 2'b00, 1'b0, 0);
      beat(32'hE2, 2'b00, 1'b0, 1);
      reset = 1'b1;
      tick();
      #1;
      chk("midrst_arvalid", ifu_arvalid, 0);
      chk("midrst_rready", ifu_rready, 0);
      chk("midrst_miss_ready", miss_ready, 1);
      chk("midrst_fill_done", fill_done, 0);
      chk("midrst_araddr", ifu_araddr, 0);
      reset = 1'b0;
      tick();

      // Fresh miss after reset restarts at index 0
      start(32'h1234_567F, 32'h1234_5670, 0, 1'b0);
      beat(32'hF1, 2'b00, 1'b0, 0);
      beat(32'hF2, 2'b00, 1'b0, 1);
      beat(32'hF3, 2'b00, 1'b0, 2);
      beat(32'hF4, 2'b00, 1'b1, 3);
      finish(1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
